rv32i_inst_encoder: RTL and testbench

- Streaming RV32I instruction encoder: the inverse of the package field decoder.
- Accepts decoded fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) and packs them into a 32-bit instruction word according to the opcode's format (R/I/S/B/U/J).
- Range-checks every field set; flags errors rather than emitting a corrupt word.
- Two-stage valid/ready pipeline; used by the test-program generator and the debug-injection path ahead of fetch.

---
 rtl/rv32i_inst_encoder.sv | 163 ++++++++++++++++
 tb/tb_rv32i_inst_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_inst_encoder.sv
// RV32I field-to-word encoder: two-stage valid/ready pipeline that packs decoded
// fields by opcode format and flags unencodable field sets instead of emitting them.
module rv32i_inst_encoder #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [6:0]             in_opcode,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_rs1,
   input  logic [4:0]             in_rs2,
   input  logic [2:0]             in_funct3,
   input  logic [6:0]             in_funct7,
   input  logic [31:0]            in_imm,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_inst,
   output logic                   out_error,
   input  logic                   count_clear,
   output logic [COUNT_WIDTH-1:0] encoded_count,
   output logic [COUNT_WIDTH-1:0] error_count
);

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

   typedef struct packed {
      fmt_e        fmt;
      logic        err;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } enc_req_t;

   logic [2:1] vld_pipe;
   logic       s2_free;
   enc_req_t   s1_d, s1_q;
   logic [31:0] word;
   logic       imm12_ok, b_ok, j_ok, shamt_ok;

   assign s2_free   = !vld_pipe[2] || out_ready;
   assign in_ready  = !vld_pipe[1] || s2_free;
   assign out_valid = vld_pipe[2];

   // Range checks are expressed as "upper bits are a pure sign extension".
   assign imm12_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
   assign b_ok     = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
   assign j_ok     = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
   assign shamt_ok = (in_imm[31:5] == '0) ||
                     ((in_funct3 == 3'd5) && (in_imm[31:5] == {20'h0, 7'h20}));

   always_comb begin
      s1_d     = '0;
      s1_d.op  = in_opcode;
      s1_d.rd  = in_rd;
      s1_d.rs1 = in_rs1;
      s1_d.rs2 = in_rs2;
      s1_d.f3  = in_funct3;
      s1_d.f7  = in_funct7;
      s1_d.imm = in_imm;
      s1_d.fmt = FMT_X;
      s1_d.err = 1'b0;
      case (in_opcode)
         7'h33: begin
            s1_d.fmt = FMT_R;
            if (in_funct7 == 7'h00)
               s1_d.err = 1'b0;
            else if (in_funct7 == 7'h20)
               s1_d.err = !((in_funct3 == 3'd0) || (in_funct3 == 3'd5));
            else
               s1_d.err = 1'b1;
         end
         7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
            s1_d.fmt = FMT_I;
            s1_d.err = !imm12_ok;
            if ((in_opcode == 7'h13) && ((in_funct3 == 3'd1) || (in_funct3 == 3'd5)))
               s1_d.err = !shamt_ok;
            if ((in_opcode == 7'h03) && ((in_funct3 == 3'd3) || (in_funct3 == 3'd6) ||
                                         (in_funct3 == 3'd7)))
               s1_d.err = 1'b1;
         end
         7'h23: begin
            s1_d.fmt = FMT_S;
            s1_d.err = !imm12_ok;
         end
         7'h63: begin
            s1_d.fmt = FMT_B;
            s1_d.err = !b_ok || (in_funct3 == 3'd2) || (in_funct3 == 3'd3);
         end
         7'h37, 7'h17: begin
            s1_d.fmt = FMT_U;
            s1_d.err = (in_imm[11:0] != 12'h0);
         end
         7'h6F: begin
            s1_d.fmt = FMT_J;
            s1_d.err = !j_ok;
         end
         default: begin
            s1_d.fmt = FMT_X;
            s1_d.err = 1'b1;
         end
      endcase
   end

   always_comb begin
      word = '0;
      case (s1_q.fmt)
         FMT_R: word = {s1_q.f7, s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
         FMT_I: word = {s1_q.imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.op};
         FMT_S: word = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.imm[4:0], s1_q.op};
         FMT_B: word = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.f3,
                        s1_q.imm[4:1], s1_q.imm[11], s1_q.op};
         FMT_U: word = {s1_q.imm[31:12], s1_q.rd, s1_q.op};
         FMT_J: word = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                        s1_q.rd, s1_q.op};
         default: word = '0;
      endcase
      if (s1_q.err)
         word = '0;
   end

   // Stage-1 payload needs no reset; it is only observed behind vld_pipe[1].
   always_ff @(posedge clk) begin
      if (in_ready && in_valid)
         s1_q <= s1_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         out_inst  <= '0;
         out_error <= 1'b0;
      end else begin
         if (in_ready)
            vld_pipe[1] <= in_valid;
         if (s2_free) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               out_inst  <= word;
               out_error <= s1_q.err;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || count_clear) begin
         encoded_count <= '0;
         error_count   <= '0;
      end else if (out_valid && out_ready) begin
         if (out_error)
            error_count <= error_count + COUNT_WIDTH'(1);
         else
            encoded_count <= encoded_count + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Scoreboard bench for rv32i_inst_encoder: expectations queued at input accept,
// compared at output handshake; directed vectors plus a numeric-range reference model.
module tb_rv32i_inst_encoder;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid, in_ready, out_valid, out_ready, out_error, count_clear;
   logic [6:0]    in_opcode, in_funct7;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [2:0]    in_funct3;
   logic [31:0]   in_imm, out_inst;
   logic [CW-1:0] encoded_count, error_count;

   rv32i_inst_encoder #(.COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_error(out_error),
      .count_clear(count_clear),
      .encoded_count(encoded_count), .error_count(error_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic        err;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            n_tests = 0;
   int            n_fail = 0;
   logic [31:0]   exp_inst_drv = '0;
   logic          exp_err_drv = 1'b0;
   logic [CW-1:0] m_enc = '0;
   logic [CW-1:0] m_err = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   // Reference encoder written with numeric ranges rather than bit patterns.
   function automatic exp_t ref_enc(input logic [6:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] imm);
      exp_t r;
      logic bad;
      bad = 1'b0;
      r.inst = '0;
      case (op)
         7'h33: begin
            bad = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
            r.inst = {f7, rs2, rs1, f3, rd, op};
         end
         7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
            bad = ($signed(imm) < -2048) || ($signed(imm) > 2047);
            if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
               bad = !((imm < 32) || (f3 == 3'd5 && imm >= 32'h400 && imm < 32'h420));
            if (op == 7'h03 && (f3 == 3'd3 || f3 >= 3'd6))
               bad = 1'b1;
            r.inst = {imm[11:0], rs1, f3, rd, op};
         end
         7'h23: begin
            bad = ($signed(imm) < -2048) || ($signed(imm) > 2047);
            r.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         end
         7'h63: begin
            bad = ($signed(imm) < -4096) || ($signed(imm) > 4095) || imm[0] ||
                  (f3 == 3'd2) || (f3 == 3'd3);
            r.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         end
         7'h37, 7'h17: begin
            bad = (imm % 4096) != 0;
            r.inst = {imm[31:12], rd, op};
         end
         7'h6F: begin
            bad = ($signed(imm) < -1048576) || ($signed(imm) > 1048575) || imm[0];
            r.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         end
         default: bad = 1'b1;
      endcase
      if (bad)
         r.inst = '0;
      r.err = bad;
      return r;
   endfunction

   // Handshakes are judged at the falling edge; inputs only move just after rising edges.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         m_enc <= '0;
         m_err <= '0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
               mon_e.err = out_error;
            end else begin
               mon_e = sb.pop_front();
               chk("inst", out_inst, mon_e.inst);
               chk("error", {31'h0, out_error}, {31'h0, mon_e.err});
            end
         end
         if (count_clear) begin
            m_enc <= '0;
            m_err <= '0;
         end else if (out_valid && out_ready) begin
            if (mon_e.err) m_err <= m_err + 1;
            else           m_enc <= m_enc + 1;
         end
         if (in_valid && in_ready) begin
            mon_e.inst = exp_inst_drv;
            mon_e.err  = exp_err_drv;
            sb.push_back(mon_e);
         end
      end
   end

   task automatic present(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm, input logic [31:0] xi, input logic xe);
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      exp_inst_drv = xi; exp_err_drv = xe;
      in_valid = 1'b1;
   endtask

   task automatic present_m(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
      exp_t e;
      e = ref_enc(op, rd, rs1, rs2, f3, f7, imm);
      present(op, rd, rs1, rs2, f3, f7, imm, e.inst, e.err);
   endtask

   task automatic wait_accept(output int stalls);
      stalls = 0;
      @(negedge clk);
      while (!in_ready && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] xi, input logic xe,
                       output int stalls);
      present(op, rd, rs1, rs2, f3, f7, imm, xi, xe);
      wait_accept(stalls);
   endtask

   task automatic send_m(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] imm);
      int st;
      present_m(op, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm);
      wait_accept(st);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st, k, sent;
      logic [31:0] held, r;
      logic [6:0] ops [9];
      bit have, stale;
      ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h67};

      in_valid = 0; out_ready = 1; count_clear = 0;
      in_opcode = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
      in_funct3 = 0; in_funct7 = 0; in_imm = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_enc_cnt", encoded_count, 0);
      chk("rst_err_cnt", error_count, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // addi x1,x0,5 and its two-cycle latency
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, st);
      @(negedge clk); chk("addi_lat_c1", out_valid, 0);
      @(negedge clk); chk("addi_lat_c2", out_valid, 1);
      @(negedge clk); chk("addi_enc_cnt", encoded_count, 1);
      @(posedge clk); #1;

      send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0, st);
      chk("add_no_stall", st, 0);
      send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3, 1'b0, st);
      chk("sub_no_stall", st, 0);
      send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0, st);
      send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, st);
      send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0, st);
      send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, st);
      drain();
      chk("enc_cnt_7", encoded_count, 7);

      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h0, 1'b1, st);
      send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0, 1'b1, st);
      send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h0, 1'b1, st);
      drain();
      chk("err_cnt_3", error_count, 3);
      chk("enc_cnt_kept", encoded_count, 7);

      // backpressure: four offered, two fit, then a release cycle takes the third
      out_ready = 0; k = 0;
      present_m(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      held = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 2) held = out_inst;
         if (c == 3) chk("bp_hold_valid", out_valid, 1);
         if (in_ready) k++;
         @(posedge clk); #1;
         present_m(7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1));
      end
      chk("bp_accepted", k, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_inst_held", out_inst, held);
      out_ready = 1;
      for (int c = 0; c < 10 && k < 4; c++) begin
         @(negedge clk);
         if (c == 0) chk("bp_release_accept", in_ready, 1);
         if (in_ready) k++;
         @(posedge clk); #1;
         if (k < 4) present_m(7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1));
         else in_valid = 0;
      end
      chk("bp_all_accepted", k, 4);
      drain();

      // random mix with random backpressure
      sent = 0; have = 0;
      for (int c = 0; c < 600 && sent < 40; c++) begin
         if (!have) begin
            r = $urandom;
            case ($urandom_range(0, 3))
               0: r = {{20{r[11]}}, r[11:0]};
               1: r = {{19{r[12]}}, r[12:1], 1'b0};
               2: r = {r[31:12], 12'h0};
               default: r = r;
            endcase
            present_m(ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom), 5'($urandom),
                      3'($urandom), ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00, r);
            have = 1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_ready) begin
            sent++;
            have = 0;
         end
         @(posedge clk); #1;
         if (!have) in_valid = 0;
      end
      in_valid = 0; out_ready = 1;
      chk("rnd_sent", sent, 40);
      drain();
      chk("rnd_enc_cnt", encoded_count, m_enc);
      chk("rnd_err_cnt", error_count, m_err);

      // reset with two entries in flight
      out_ready = 0;
      send_m(7'h13, 5'd7, 32'd7);
      send_m(7'h13, 5'd8, 32'd8);
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_enc_cnt", encoded_count, 0);
      chk("rst2_err_cnt", error_count, 0);
      chk("rst2_in_ready", in_ready, 1);
      out_ready = 1; stale = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (out_valid) stale = 1;
      end
      chk("rst2_no_stale", stale, 0);
      @(posedge clk); #1;

      // clear coincident with an output handshake
      send_m(7'h13, 5'd2, 32'd2);
      drain();
      chk("pre_clear_enc", encoded_count, 1);
      out_ready = 0;
      send_m(7'h13, 5'd3, 32'd3);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      chk("clr_wait_valid", out_valid, 1);
      @(posedge clk); #1;
      out_ready = 1; count_clear = 1;
      @(posedge clk); #1;
      count_clear = 0;
      @(negedge clk);
      chk("clr_enc_cnt", encoded_count, 0);
      chk("clr_err_cnt", error_count, 0);
      chk("clr_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
